// File: rtl/credit_fifo_stage_pkg.sv
// Shared constants, event bundle and pointer helper for the credit-managed FIFO stage.
package credit_fifo_stage_pkg;

  localparam int CFS_PATH_BITS       = 16;
  localparam int CFS_DEFAULT_DEPTH   = 2;
  localparam int CFS_DEFAULT_CREDITS = 1;

  typedef struct packed {
    logic send;
    logic push;
    logic saturate;
  } cfs_evt_t;

  // Pointer advance modulo an arbitrary depth (not restricted to powers of two).
  function automatic int unsigned cfs_wrap_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr + 32'd1 >= depth) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/credit_fifo_stage_if.sv
// Link-side signals of credit_fifo_stage; slave = the stage, master = its environment.
// err_out exists only when CREDIT_FIFO_OVERFLOW_CHK_EN is defined.
interface credit_fifo_stage_if
  import credit_fifo_stage_pkg::*;
#(
  parameter int BITS  = CFS_PATH_BITS,
  parameter int DEPTH = CFS_DEFAULT_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            valid_in;
  logic [BITS-1:0] data_in;
  logic            credit_out;
  logic            valid_out;
  logic [BITS-1:0] data_out;
  logic            credit_in;
  logic [CW-1:0]   occupancy;
`ifdef CREDIT_FIFO_OVERFLOW_CHK_EN
  logic            err_out;

  modport slave (
    input  valid_in, data_in, credit_in,
    output credit_out, valid_out, data_out, occupancy, err_out
  );

  modport master (
    output valid_in, data_in, credit_in,
    input  credit_out, valid_out, data_out, occupancy, err_out
  );
`else
  modport slave (
    input  valid_in, data_in, credit_in,
    output credit_out, valid_out, data_out, occupancy
  );

  modport master (
    output valid_in, data_in, credit_in,
    input  credit_out, valid_out, data_out, occupancy
  );
`endif

endinterface

// File: rtl/credit_fifo_stage_stage_fifo.sv
// stage_fifo: synchronous FIFO of any DEPTH >= 1 with push-while-full when a pop
// happens at the same edge. Head data is read combinationally from storage.
module stage_fifo
  import credit_fifo_stage_pkg::*;
#(
  parameter int BITS  = CFS_PATH_BITS,
  parameter int DEPTH = CFS_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [BITS-1:0]            wdata_i,
  output logic [BITS-1:0]            head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_s, empty_s, do_pop_s, do_push_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q == CW'(1'b0));
  assign do_pop_s  = pop_i && !empty_s;
  assign do_push_s = push_i && (!full_s || do_pop_s);

  // Pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop_s) begin
      rd_ptr_d = PW'(cfs_wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s) begin
      wr_ptr_d = PW'(cfs_wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule

// File: rtl/credit_fifo_stage.sv
// credit_fifo_stage: buffers fabric tokens and forwards them only while a downstream
// credit is held, returning one upstream credit per freed slot. Optional CREDIT_FIFO_OVERFLOW_CHK_EN.
module credit_fifo_stage
  import credit_fifo_stage_pkg::*;
#(
  parameter int ID      = 0,
  parameter int BITS    = CFS_PATH_BITS,
  parameter int DEPTH   = CFS_DEFAULT_DEPTH,
  parameter int CREDITS = CFS_DEFAULT_CREDITS
) (
  input logic               clk,
  input logic               rst,
  credit_fifo_stage_if.slave bus
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CRW = (CREDITS > 1) ? $clog2(CREDITS + 1) : 1;

  if ((DEPTH < 1) || (CREDITS < 1) || (ID < 0)) begin : g_bad_cfg
    $error("credit_fifo_stage: invalid DEPTH/CREDITS/ID");
  end

  cfs_evt_t        evt_s;
  logic [BITS-1:0] head_s;
  logic [CW-1:0]   count_s;
  logic            full_s, empty_s;
  logic [CRW-1:0]  credit_q, credit_d;
  logic            valid_out_q, credit_out_q;
  logic [BITS-1:0] data_out_q, data_out_d;

  stage_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (evt_s.push),
    .pop_i   (evt_s.send),
    .wdata_i (bus.data_in),
    .head_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Send uses the registered credit count, so a same-cycle credit_in cannot enable it.
  always_comb begin
    evt_s          = '{send: 1'b0, push: 1'b0, saturate: 1'b0};
    evt_s.send     = !empty_s && (credit_q != {CRW{1'b0}});
    evt_s.push     = bus.valid_in && (!full_s || evt_s.send);
    evt_s.saturate = bus.credit_in && !evt_s.send && (credit_q == CRW'(CREDITS));
    credit_d       = credit_q;
    if (evt_s.saturate) begin
      credit_d = credit_q;
    end else if (bus.credit_in && !evt_s.send) begin
      credit_d = credit_q + CRW'(1'b1);
    end else if (!bus.credit_in && evt_s.send) begin
      credit_d = credit_q - CRW'(1'b1);
    end else begin
      credit_d = credit_q;
    end
    if (evt_s.send) begin
      data_out_d = head_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q     <= CRW'(CREDITS);
      valid_out_q  <= 1'b0;
      credit_out_q <= 1'b0;
      data_out_q   <= {BITS{1'b0}};
    end else begin
      credit_q     <= credit_d;
      valid_out_q  <= evt_s.send;
      credit_out_q <= evt_s.send;
      data_out_q   <= data_out_d;
    end
  end

  assign bus.valid_out  = valid_out_q;
  assign bus.credit_out = credit_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.occupancy  = count_s;

`ifdef CREDIT_FIFO_OVERFLOW_CHK_EN
  logic overflow_s;
  logic err_q;

  assign overflow_s = bus.valid_in && full_s && !evt_s.send;

  // Sticky protocol-error flag: overflow drop or credit saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q || overflow_s || evt_s.saturate;
    end
  end

  assign bus.err_out = err_q;
`endif

endmodule
